// File: rtl/c_stream_receiver.sv
// Serial C-matrix stream receiver: synchronizes the bit stream, rebuilds one frame and drains it
// element by element through a valid/ready port while the next frame is being captured.
module c_stream_receiver #(
  parameter int unsigned ACCW        = 32,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_clk,
  input  logic                          serial_data,
  input  logic                          frame_sync,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACCW-1:0]               out_data,
  output logic [$clog2(ROWS*COLS)-1:0]  out_index,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned Elems = ROWS * COLS;
  localparam int unsigned N     = Elems * ACCW;
  localparam int unsigned IdxW  = $clog2(Elems);
  localparam int unsigned CntW  = $clog2(N + 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRecv     = 2'd1;
  localparam logic [1:0] StComplete = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, data_sync_q, fsync_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, data_s, fsync_s, strobe;
  logic                   armed_q, armed_d;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    shift_q, shift_d, shift_in;
  logic            handoff;

  logic [N-1:0]    hold_q, hold_d;
  logic            full_q, full_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic            accept, last_accept, buf_free;

  // Sync stage resets high so a frame already in flight at reset release is not armed on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      data_sync_q  <= '0;
      fsync_sync_q <= '1;
      sclk_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], serial_clk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], serial_data};
      fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], frame_sync};
      sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign fsync_s  = fsync_sync_q[SYNC_STAGES-1];
  assign strobe   = sclk_s & ~sclk_prev_q;
  assign armed_d  = armed_q | ~fsync_s;
  assign shift_in = {shift_q[N-2:0], data_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    handoff = 1'b0;
    case (state_q)
      StIdle: begin
        if (armed_q && strobe && fsync_s) begin
          shift_d = {{(N-1){1'b0}}, data_s};
          cnt_d   = CntW'(1);
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (!fsync_s) begin
          shift_d = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (strobe) begin
          shift_d = shift_in;
          if (cnt_q == CntW'(N - 1)) begin
            handoff = 1'b1;
            cnt_d   = '0;
            state_d = StComplete;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StComplete: begin
        if (!fsync_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept      = full_q & out_ready;
  assign last_accept = accept && (idx_q == IdxW'(Elems - 1));
  assign buf_free    = ~full_q | last_accept;

  // The final bit goes straight from the shifter input into the hold buffer on the same edge.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    ovf_d  = 1'b0;
    if (accept) begin
      if (last_accept) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
    if (handoff) begin
      if (buf_free) begin
        hold_d = shift_in;
        full_d = 1'b1;
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = full_q;
  assign out_data   = full_q ? hold_q[idx_q*ACCW +: ACCW] : '0;
  assign out_index  = idx_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_c_stream_receiver.sv
// Scoreboard bench for c_stream_receiver: frames are pushed as expected beats when driven and
// popped by a negedge monitor on every accepted transfer.
module tb_c_stream_receiver;

  localparam int unsigned Sync  = 2;
  localparam int unsigned Elems = 16;
  localparam int          N     = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial_clk = 1'b0;
  logic        serial_data = 1'b0;
  logic        frame_sync = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        frame_done, frame_err, overflow;

  c_stream_receiver #(
    .ACCW        (32),
    .ROWS        (4),
    .COLS        (4),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_clk  (serial_clk),
    .serial_data (serial_data),
    .frame_sync  (frame_sync),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          half = 4;
  int          done_cnt = 0, err_cnt = 0, ovf_cnt = 0, valid_cycles = 0;
  logic [63:0] sb[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  logic        bp_stop;
  logic [N-1:0] f, g;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_on();
    frame_sync = 1'b1;
    wait_clk(half);
  endtask

  task automatic send_bit(input logic b);
    serial_data = b;
    wait_clk(half);
    serial_clk = 1'b1;
    wait_clk(half);
    serial_clk = 1'b0;
  endtask

  task automatic sync_off();
    wait_clk(half);
    frame_sync = 1'b0;
    wait_clk(half + 6);
  endtask

  task automatic send_range(input logic [N-1:0] fr, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(fr[i]);
  endtask

  task automatic send_frame(input logic [N-1:0] fr);
    sync_on();
    send_range(fr, N - 1, 0);
    sync_off();
  endtask

  task automatic push_frame(input logic [N-1:0] fr);
    for (int i = 0; i < int'(Elems); i++) sb.push_back({32'(i), fr[i*32 +: 32]});
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 3000 && (sb.size() != 0 || out_valid); k++) wait_clk(1);
    check("drain_empty", 64'(sb.size()), 0);
    check("drain_idle", out_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {out_valid, frame_done, frame_err, overflow, out_index, out_data}, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_index", out_index, prev_idx);
      end
      if (frame_done || frame_err || overflow)
        check("pulse_excl", 64'($countones({frame_done, frame_err, overflow})), 1);
      if (frame_done) begin
        done_cnt++;
        check("done_valid", {out_valid, out_index}, {1'b1, 4'd0});
      end
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        check("sb_has_entry", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          logic [63:0] e;
          e = sb.pop_front();
          check("beat_index", out_index, e[63:32]);
          check("beat_data", out_data, e[31:0]);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_index;
    end
  end

  initial begin
    wait_clk(3);
    check_zero("reset_held");
    rst_n = 1'b1;
    wait_clk(5);
    check_zero("reset_release");

    // Single frame, consumer always ready.
    for (int i = 0; i < int'(Elems); i++) f[i*32 +: 32] = 32'h1000_0000 + i;
    valid_cycles = 0;
    push_frame(f);
    out_ready = 1'b1;
    send_frame(f);
    wait_drain();
    check("single_done", 64'(done_cnt), 1);
    check("single_beats", 64'(valid_cycles), 16);

    // Same frame under random backpressure.
    push_frame(f);
    bp_stop = 1'b0;
    fork
      begin
        send_frame(f);
        wait_drain();
        bp_stop = 1'b1;
      end
      begin
        while (!bp_stop) begin
          out_ready = 1'($urandom_range(0, 1));
          wait_clk(1);
        end
      end
    join
    out_ready = 1'b1;
    check("bp_done", 64'(done_cnt), 2);

    // Short frame of 300 bits, then a full frame.
    valid_cycles = 0;
    for (int i = 0; i < N / 32; i++) g[i*32 +: 32] = $urandom;
    sync_on();
    send_range(g, N - 1, N - 300);
    sync_off();
    check("short_err", 64'(err_cnt), 1);
    check("short_novalid", 64'(valid_cycles), 0);
    check("short_nodone", 64'(done_cnt), 2);
    for (int i = 0; i < int'(Elems); i++) f[i*32 +: 32] = 32'hDEAD_BEEF;
    push_frame(f);
    send_frame(f);
    wait_drain();
    check("after_short_done", 64'(done_cnt), 3);

    // Overflow: B arrives while A is still held.
    for (int i = 0; i < int'(Elems); i++) f[i*32 +: 32] = 32'hA000_0000 + i;
    for (int i = 0; i < int'(Elems); i++) g[i*32 +: 32] = 32'hB000_0000 + i;
    out_ready = 1'b0;
    push_frame(f);
    send_frame(f);
    send_frame(g);
    check("ovf_pulse", 64'(ovf_cnt), 1);
    check("ovf_done", 64'(done_cnt), 4);
    out_ready = 1'b1;
    wait_drain();

    // Last element of A accepted on the very edge B completes: no overflow.
    out_ready = 1'b0;
    push_frame(f);
    send_frame(f);
    sync_on();
    send_range(g, N - 1, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && out_index != 4'd15; k++) wait_clk(1);
    out_ready = 1'b0;
    check("edge_idx15", out_index, 15);
    serial_data = g[0];
    wait_clk(half);
    serial_clk = 1'b1;
    wait_clk(Sync);
    out_ready = 1'b1;
    wait_clk(1);
    out_ready = 1'b0;
    wait_clk(half - Sync - 1);
    serial_clk = 1'b0;
    sync_off();
    push_frame(g);
    check("edge_no_ovf", 64'(ovf_cnt), 1);
    check("edge_done", 64'(done_cnt), 6);
    out_ready = 1'b1;
    wait_drain();

    // Reset at bit 200; the remainder of that frame must be ignored.
    for (int i = 0; i < N / 32; i++) g[i*32 +: 32] = $urandom;
    sync_on();
    send_range(g, N - 1, N - 200);
    rst_n = 1'b0;
    #1;
    check_zero("rst_frame");
    sb.delete();
    wait_clk(2);
    rst_n = 1'b1;
    send_range(g, N - 201, 0);
    sync_off();
    check("rst_frame_nodone", 64'(done_cnt), 6);
    check("rst_frame_noerr", 64'(err_cnt), 1);
    check("rst_frame_idle", out_valid, 0);

    // Reset mid-drain at index 7.
    for (int i = 0; i < int'(Elems); i++) f[i*32 +: 32] = $urandom;
    push_frame(f);
    out_ready = 1'b0;
    send_frame(f);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && out_index != 4'd7; k++) wait_clk(1);
    out_ready = 1'b0;
    check("drain_idx7", {out_valid, out_index}, {1'b1, 4'd7});
    rst_n = 1'b0;
    #1;
    check_zero("rst_drain");
    sb.delete();
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);
    check_zero("rst_drain_after");
    check("rst_drain_done", 64'(done_cnt), 7);

    // Minimum-rate serial clock with random data.
    half = Sync + 1;
    for (int i = 0; i < N / 32; i++) f[i*32 +: 32] = $urandom;
    push_frame(f);
    out_ready = 1'b1;
    send_frame(f);
    wait_drain();
    check("minrate_done", 64'(done_cnt), 8);
    check("final_pulses", 64'({err_cnt[7:0], ovf_cnt[7:0]}), 64'({8'd1, 8'd1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c_stream_receiver.md
# c_stream_receiver

Receives the serial C-matrix stream (data, serial clock, frame sync) produced by the systolic array's serial output port and rebuilds the ROWS×COLS result matrix. It then drains the matrix one ACCW-bit element per valid/ready handshake to the downstream result consumer (writeback or host FIFO). The serial inputs are sampled in the system clock domain. A one-frame holding buffer lets the next frame be captured while the previous one drains.

## Interface
- ACCW, 32, element width in bits
- ROWS, 4, matrix rows
- COLS, 4, matrix columns
- SYNC_STAGES, 2, synchronizer depth on the serial inputs (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- serial_clk  input  1  stream bit clock, asynchronous to clk
- serial_data  input  1  stream data, MSB of frame first
- frame_sync  input  1  high for the whole frame
- out_valid  output  1  out_data/out_index valid
- out_ready  input  1  consumer accepts the element
- out_data  output  ACCW  matrix element
- out_index  output  $clog2(ROWS*COLS)  element index, row-major (r*COLS+c)
- frame_done  output  1  one-cycle pulse when a full frame is captured
- frame_err  output  1  one-cycle pulse when a short frame is discarded
- overflow  output  1  one-cycle pulse when a complete frame is dropped

## Operation
- Frame length N = ROWS*COLS*ACCW bits (512 by default). Element i occupies frame bits [i*ACCW+ACCW-1 : i*ACCW]. Bits are transmitted MSB-first, so element ROWS*COLS-1 arrives first.
- serial_clk, serial_data and frame_sync each pass through SYNC_STAGES flops. A rising edge of the synchronized serial_clk is a bit strobe. Data and sync are sampled from the same synchronized stage as the strobe.
- Capture FSM:
  - IDLE: on a strobe with sync=1, shift the bit in, set bit count to 1, go to RECV.
  - RECV: on each strobe with sync=1, shift and increment the count. When the count reaches N, go to COMPLETE.
  - RECV, short frame: if sync falls before N bits, discard the shift register, pulse frame_err, go to IDLE.
  - COMPLETE: wait for sync=0, then go to IDLE. Strobes in this state are ignored without error.
- Hand-off on reaching N:
  - Hold buffer free: copy the shift register into the hold buffer, pulse frame_done, set drain index to 0.
  - Hold buffer busy: drop the frame, pulse overflow. frame_done does not pulse.
  - The hold buffer counts as free in the same cycle its last element is accepted.
- Drain:
  - While the hold buffer is full, out_valid=1, out_data = hold element[index], out_index = index.
  - out_valid&&out_ready advances the index.
  - Acceptance of index ROWS*COLS-1 empties the buffer; out_valid drops next cycle unless a new frame is copied in that same cycle.
- out_data and out_index stay stable while out_valid=1 && out_ready=0.
- Reset (any time, including mid-frame or mid-drain): FSM to IDLE, count, index and buffers cleared, all outputs 0. A frame in progress when reset releases is ignored until sync is seen low.

## Timing
- Reset values: out_valid=0, out_data=0, out_index=0, frame_done=0, frame_err=0, overflow=0.
- Input latency: SYNC_STAGES+1 clk cycles from a serial_clk pin edge to the strobe.
- serial_clk high and low phases must each be ≥ SYNC_STAGES+1 clk cycles. frame_sync and serial_data must be stable ≥ SYNC_STAGES+1 clk cycles around each serial_clk rising edge.
- Bit-N strobe at cycle T: frame_done and the hold-buffer load are registered at T+1; out_valid=1 from T+1.
- Drain throughput: one element per cycle with out_ready held high. ROWS*COLS accepted transfers empty the buffer.
- frame_err is registered one cycle after the strobe-domain sync fall is detected.
- frame_done, frame_err and overflow are single-cycle pulses and never assert together.

## Test plan
- Single frame: send element i = 0x1000_0000+i (i=0..15), MSB-first, out_ready=1. Required: frame_done pulse, then 16 consecutive beats with out_index 0..15 and out_data 0x1000_0000..0x1000_000F; out_valid low afterwards.
- Backpressure: same frame with out_ready toggling randomly. Required: each element held stable until accepted, order and values unchanged, no loss.
- Short frame: drop frame_sync after 300 bits. Required: frame_err pulse, no out_valid. The next full frame (all elements 0xDEADBEEF) drains correctly.
- Overflow: send frame A, hold out_ready=0, send frame B. Required: overflow pulse at B's completion, and the drain delivers only frame A's values. Also release out_ready so the last A element is accepted in the cycle B completes; required: no overflow and B drains.
- Reset mid-operation: assert rst_n=0 at bit 200 of one frame, and separately mid-drain at index 7. Required: all outputs 0 immediately, and no frame_done for the interrupted frame.
- Minimum-rate serial_clk: half-period = SYNC_STAGES+1 clk cycles, random data. Required: a bit-exact match of all 512 bits.
